operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter DATA_W, 16, operand/result width.
REQ-002 Parameter ADDR_W, 12, operand address/immediate width.
REQ-003 Parameter DEPTH, 32, register count (2..2**ADDR_W).
REQ-004 Parameter WB_DELAY, 2, cycles from store acceptance to writeback commit (1..8).
REQ-005 Parameter OUT_ADDR, DEPTH-1, register mirrored on data_out.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 in_valid  in  1  instruction offered.
REQ-009 in_ready  out  1  instruction accepted when in_valid&in_ready.
REQ-010 is_immediate  in  1  addr is literal operand.
REQ-011 addr  in  ADDR_W  operand address / immediate / store destination.
REQ-012 is_load_in, is_store_in  in  1 each  load tag; store-result tag.
REQ-013 opcode_in  in  4  passthrough opcode.
REQ-014 data_in  in  DATA_W  external input, read at address 0.
REQ-015 alu_result  in  DATA_W  writeback data, sampled in the commit cycle.
REQ-016 out_valid  out  1; out_ready  in  1  output handshake.
REQ-017 value  out  DATA_W; is_load_out  out  1; opcode_out  out  4  fetched operand and tags.
REQ-018 data_out  out  DATA_W  registered copy of register OUT_ADDR.

Function
REQ-019 Output stage is one register slot; latency from acceptance to out_valid is exactly 1 cycle.
REQ-020 Slot loads on acceptance, clears out_valid on out_valid&out_ready with no acceptance; value/is_load_out/opcode_out stay stable while out_valid&!out_ready.
REQ-021 in_ready = (!out_valid | out_ready) & !hazard, combinational.
REQ-022 Operand select, priority order: addr==0 -> data_in; is_immediate -> addr zero-extended (truncated to DATA_W if ADDR_W>DATA_W); addr>=DEPTH -> 0; else register read.
REQ-023 Writeback pipe: WB_DELAY stages of {valid, addr}, shifting every cycle regardless of stall; stage 0 loads valid=1 only on accepted instruction with is_store_in=1.
REQ-024 Commit: when the oldest stage is valid, registers[addr] <= alu_result at that clock edge; commits to addr 0 or addr>=DEPTH are dropped.
REQ-025 Bypass: register read whose addr equals a committing (non-dropped) address returns alu_result that cycle.
REQ-026 Hazard: non-immediate, non-zero read whose addr matches any valid non-oldest stage holds in_ready=0 until that entry commits.
REQ-027 Same-instruction store and read of one address reads the pre-store value and is not a hazard.
REQ-028 data_out updates every cycle to registers[OUT_ADDR], or to alu_result when a commit to OUT_ADDR occurs that cycle.

Reset
REQ-029 rst low immediately clears out_valid, value, is_load_out, opcode_out, data_out, all pipe valid bits and all registers to 0.
REQ-030 Reset mid-operation discards pending writebacks; first commit after release requires a new store.
REQ-031 in_ready is 1 in the first cycle after release if out_ready=1.

Verification
REQ-032 Defaults: read addr 5 after reset -> value=0x0000 one cycle later, out_valid=1.
REQ-033 Store to addr 3, alu_result=0xBEEF driven 2 cycles later -> subsequent read of 3 returns 0xBEEF; read of 3 issued in the commit cycle returns 0xBEEF via bypass.
REQ-034 Store to 7 then immediately read 7 -> in_ready=0 for exactly one cycle, read accepted in commit cycle, value=alu_result.
REQ-035 addr=0, data_in=0x1234, is_immediate=1 -> value=0x1234; addr=0x0AB, is_immediate=1 -> value=0x00AB.
REQ-036 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, value/opcode_out held; released -> next instruction accepted.
REQ-037 Store to 31 pending, rst pulsed low before commit -> register 31 and data_out remain 0.

Source files
------------

// File: rtl/operand_fetch.sv
// operand_fetch: resolves one instruction operand per accepted instruction and
// presents it through a single-slot registered output stage. A register file of
// DEPTH words is written back WB_DELAY cycles after a store is accepted. Reads
// of a register that is committing in the current cycle are bypassed. Reads of a
// register that still has a younger store in flight stall the input.
//
// Ports:
//   clk, rst        clock (rising edge); asynchronous active-low reset
//   in_valid/ready  instruction handshake (in_ready is combinational)
//   is_immediate    addr is a literal operand
//   addr            operand address / immediate / store destination
//   is_load_in      load tag, carried through to is_load_out
//   is_store_in     instruction's result is written back to register addr
//   opcode_in       passthrough opcode
//   data_in         external input, returned for address 0
//   alu_result      writeback data, sampled in the commit cycle
//   out_valid/ready output handshake
//   value, is_load_out, opcode_out  fetched operand and tags
//   data_out        registered mirror of register OUT_ADDR
module operand_fetch #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 12,
  parameter int DEPTH    = 32,
  parameter int WB_DELAY = 2,
  parameter int OUT_ADDR = DEPTH - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              is_immediate,
  input  logic [ADDR_W-1:0] addr,
  input  logic              is_load_in,
  input  logic              is_store_in,
  input  logic [3:0]        opcode_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] value,
  output logic              is_load_out,
  output logic [3:0]        opcode_out,
  output logic [DATA_W-1:0] data_out
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH may equal 2**ADDR_W, so range checks need one extra bit.
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] OUT_A   = ADDR_W'(OUT_ADDR);
  localparam logic [IDX_W-1:0]  OUT_IDX = IDX_W'(OUT_ADDR);

  // Register file and writeback pipe.
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [WB_DELAY-1:0] wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0]   wb_addr_q [WB_DELAY];
  logic [ADDR_W-1:0]   wb_addr_d [WB_DELAY];

  // Output slot.
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic              is_load_q, is_load_d;
  logic [3:0]        opcode_q, opcode_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;

  logic              accept;
  logic              hazard;
  logic              commit_en;
  logic [ADDR_W-1:0] commit_addr;
  logic [DATA_W-1:0] operand;

  // The oldest pipe stage commits this cycle; writes to 0 or out of range drop.
  assign commit_addr = wb_addr_q[WB_DELAY-1];
  assign commit_en   = wb_valid_q[WB_DELAY-1] && (commit_addr != '0) &&
                       ({1'b0, commit_addr} < DEPTH_X);

  // Stall while a younger (not yet committing) store targets the read address.
  // The committing entry is covered by the bypass instead.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    hazard = 1'b0;
    if (!is_immediate && (addr != '0)) begin
      for (int i = 0; i < WB_DELAY - 1; i++) begin
        if (wb_valid_q[i] && (wb_addr_q[i] == addr)) hazard = 1'b1;
      end
    end
  end

  assign in_ready = (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Operand select in priority order.
  always_comb begin
    operand = '0;
    if (addr == '0)                                operand = data_in;
    else if (is_immediate)                         operand = DATA_W'(addr);
    else if ({1'b0, addr} >= DEPTH_X)              operand = '0;
    else if (commit_en && (commit_addr == addr))   operand = alu_result;
    else                                           operand = regs_q[addr[IDX_W-1:0]];
  end

  // Next state: output slot, writeback pipe, register file, data_out mirror.
  always_comb begin
    out_valid_d = out_valid_q;
    value_d     = value_q;
    is_load_d   = is_load_q;
    opcode_d    = opcode_q;
    if (accept) begin
      out_valid_d = 1'b1;
      value_d     = operand;
      is_load_d   = is_load_in;
      opcode_d    = opcode_in;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // The pipe shifts every cycle, independent of output stalls.
    wb_valid_d    = wb_valid_q << 1;
    wb_valid_d[0] = accept && is_store_in;
    wb_addr_d[0]  = addr;
    for (int i = 1; i < WB_DELAY; i++) wb_addr_d[i] = wb_addr_q[i-1];

    regs_d = regs_q;
    if (commit_en) regs_d[commit_addr[IDX_W-1:0]] = alu_result;

    data_out_d = (commit_en && (commit_addr == OUT_A)) ? alu_result : regs_q[OUT_IDX];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the register file is cleared on reset like any other state, so
      // reads after reset return 0 rather than stale contents.
      regs_q      <= '{default: '0};
      wb_valid_q  <= '0;
      wb_addr_q   <= '{default: '0};
      out_valid_q <= 1'b0;
      value_q     <= '0;
      is_load_q   <= 1'b0;
      opcode_q    <= '0;
      data_out_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its pre-edge inputs regardless of statement order.
      regs_q      <= regs_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      out_valid_q <= out_valid_d;
      value_q     <= value_d;
      is_load_q   <= is_load_d;
      opcode_q    <= opcode_d;
      data_out_q  <= data_out_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign value       = value_q;
  assign is_load_out = is_load_q;
  assign opcode_out  = opcode_q;
  assign data_out    = data_out_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed testbench for operand_fetch with default parameters
// (DATA_W=16, ADDR_W=12, DEPTH=32, WB_DELAY=2, OUT_ADDR=31).
// Inputs change 1 time unit after the rising edge; registered outputs are
// checked there, and in_ready is checked 1 time unit after inputs settle.
module tb_operand_fetch;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        is_immediate;
  logic [11:0] addr;
  logic        is_load_in;
  logic        is_store_in;
  logic [3:0]  opcode_in;
  logic [15:0] data_in;
  logic [15:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] value;
  logic        is_load_out;
  logic [3:0]  opcode_out;
  logic [15:0] data_out;

  int errors = 0;
  int checks = 0;

  operand_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .is_immediate (is_immediate),
    .addr         (addr),
    .is_load_in   (is_load_in),
    .is_store_in  (is_store_in),
    .opcode_in    (opcode_in),
    .data_in      (data_in),
    .alu_result   (alu_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .value        (value),
    .is_load_out  (is_load_out),
    .opcode_out   (opcode_out),
    .data_out     (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic imm, input logic [11:0] a, input logic ld,
                       input logic st, input logic [3:0] op);
    in_valid     = 1'b1;
    is_immediate = imm;
    addr         = a;
    is_load_in   = ld;
    is_store_in  = st;
    opcode_in    = op;
  endtask

  task automatic idle();
    in_valid     = 1'b0;
    is_immediate = 1'b0;
    addr         = '0;
    is_load_in   = 1'b0;
    is_store_in  = 1'b0;
    opcode_in    = '0;
  endtask

  initial begin
    rst        = 1'b1;
    out_ready  = 1'b1;
    data_in    = 16'h0000;
    alu_result = 16'h0000;
    idle();

    // Reset state.
    #2 rst = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_value", 32'(value), 32'h0);
    check("rst_opcode", 32'(opcode_out), 32'h0);
    check("rst_is_load", 32'(is_load_out), 32'd0);
    check("rst_data_out", 32'(data_out), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rst_in_ready", 32'(in_ready), 32'd1);

    // Read register 5 after reset.
    issue(1'b0, 12'd5, 1'b1, 1'b0, 4'hA);
    #1 check("rd5_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("rd5_out_valid", 32'(out_valid), 32'd1);
    check("rd5_value", 32'(value), 32'h0000);
    check("rd5_opcode", 32'(opcode_out), 32'hA);
    check("rd5_is_load", 32'(is_load_out), 32'd1);
    idle();
    tick();
    check("drain_out_valid", 32'(out_valid), 32'd0);

    // Address 0, immediates and out-of-range reads.
    data_in = 16'h1234;
    issue(1'b1, 12'h000, 1'b0, 1'b0, 4'h1);
    tick();
    check("addr0_value", 32'(value), 32'h1234);
    issue(1'b1, 12'h0AB, 1'b0, 1'b0, 4'h2);
    tick();
    check("imm_value", 32'(value), 32'h00AB);
    issue(1'b1, 12'h800, 1'b0, 1'b0, 4'h2);
    tick();
    check("imm_hi_value", 32'(value), 32'h0800);
    issue(1'b0, 12'd40, 1'b0, 1'b0, 4'h2);
    tick();
    check("oor_value", 32'(value), 32'h0000);
    idle();
    tick();

    // Store to 3 reads the old value; commit two cycles later, bypass, then register.
    issue(1'b0, 12'd3, 1'b0, 1'b1, 4'h3);
    #1 check("st3_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("st3_pre_value", 32'(value), 32'h0000);
    idle();
    tick();
    issue(1'b0, 12'd3, 1'b0, 1'b0, 4'h4);
    alu_result = 16'hBEEF;
    #1 check("byp3_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("byp3_value", 32'(value), 32'hBEEF);
    alu_result = 16'h1111;
    tick();
    check("reg3_value", 32'(value), 32'hBEEF);
    idle();
    tick();

    // Store to 7 followed immediately by a read of 7: one-cycle hazard.
    issue(1'b0, 12'd7, 1'b0, 1'b1, 4'h7);
    tick();
    issue(1'b0, 12'd7, 1'b0, 1'b0, 4'h8);
    #1 check("haz7_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("haz7_out_valid", 32'(out_valid), 32'd0);
    alu_result = 16'h7777;
    #1 check("haz7_commit_ready", 32'(in_ready), 32'd1);
    tick();
    check("haz7_value", 32'(value), 32'h7777);
    check("haz7_opcode", 32'(opcode_out), 32'h8);
    check("haz7_out_valid2", 32'(out_valid), 32'd1);
    idle();
    alu_result = 16'h0000;
    tick();

    // Store to OUT_ADDR updates data_out in the commit cycle.
    issue(1'b0, 12'd31, 1'b0, 1'b1, 4'h0);
    tick();
    idle();
    tick();
    alu_result = 16'hCAFE;
    #1 check("dout_before", 32'(data_out), 32'h0000);
    tick();
    check("dout_commit", 32'(data_out), 32'hCAFE);
    alu_result = 16'h0000;
    tick();
    check("dout_hold", 32'(data_out), 32'hCAFE);

    // Output stall for 3 cycles holds the slot and blocks the input.
    issue(1'b1, 12'h055, 1'b0, 1'b0, 4'h5);
    tick();
    check("stall_first", 32'(value), 32'h0055);
    out_ready = 1'b0;
    issue(1'b1, 12'h066, 1'b1, 1'b0, 4'h6);
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
      check("stall_value", 32'(value), 32'h0055);
      check("stall_opcode", 32'(opcode_out), 32'h5);
      check("stall_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1 check("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("release_value", 32'(value), 32'h0066);
    check("release_opcode", 32'(opcode_out), 32'h6);
    idle();
    tick();

    // Reset while a store to 31 is pending discards it.
    issue(1'b0, 12'd31, 1'b0, 1'b1, 4'h9);
    tick();
    idle();
    #1 rst = 1'b0;
    #1;
    check("mid_rst_data_out", 32'(data_out), 32'h0000);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    tick();
    rst = 1'b1;
    alu_result = 16'h5555;
    repeat (3) tick();
    check("post_rst_data_out", 32'(data_out), 32'h0000);
    issue(1'b0, 12'd31, 1'b0, 1'b0, 4'h1);
    tick();
    check("post_rst_reg31", 32'(value), 32'h0000);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
